// File: rtl/comet2_pkg.sv
// comet2_pkg: shared definitions for the COMET II fetch/sequencing unit.
// Holds the FSM state encodings (also visible on the fetch unit's `state`
// port) and the NOP opcode constant.
`timescale 1ns/1ps
package comet2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_INIT  = 3'b001,
        ST_IFET1 = 3'b010,
        ST_IFET2 = 3'b011,
        ST_EXEC  = 3'b100,
        ST_FAULT = 3'b101
    } state_t;

    localparam logic [7:0] OP_NOP = 8'h00;

endpackage

// File: rtl/comet2_oplen_decode.sv
// comet2_oplen_decode: combinational instruction-length classifier.
// Ports:
//   op_code  in  8  opcode byte (IR1[15:8])
//   one_word out 1  single-word, non-NOP instruction
//   two_word out 1  instruction carries a second (address) word
//   is_nop   out 1  opcode is the NOP
// Shared by the fetch sequencer and the execute-stage decoder.
`timescale 1ns/1ps
module comet2_oplen_decode
    import comet2_pkg::*;
(
    input  logic [7:0] op_code,
    output logic       one_word,
    output logic       two_word,
    output logic       is_nop
);

    logic grp_a;   // families 0x1x..0x5x, low quarter only (op_code[3:2] == 0)
    logic grp_b;   // whole 0x6x row
    logic grp_c;   // isolated two-word opcodes

    assign grp_a = (op_code[3:2] == 2'b00) &&
                   (op_code[7:4] >= 4'h1) && (op_code[7:4] <= 4'h5);
    assign grp_b = (op_code[7:4] == 4'b0110);
    assign grp_c = (op_code == 8'h70) || (op_code == 8'h80) || (op_code == 8'hF0);

    assign two_word = grp_a || grp_b || grp_c;
    assign is_nop   = (op_code == OP_NOP);
    assign one_word = !two_word && !is_nop;

endmodule

// File: rtl/comet2_fetch_unit.sv
// comet2_fetch_unit: COMET II instruction fetch and sequencing FSM.
// Owns the PC, fetches one- or two-word instructions over a req/ack read
// port (wait states allowed, bounded by TIMEOUT), and presents each one to
// execute with an ir_valid/exec_done handshake. Supports branch redirect.
// Ports:
//   mclk, rst            clock, synchronous active-high reset
//   init                 start request (IDLE/FAULT only)
//   mem_req/mem_addr     read request and address (address == PC)
//   mem_ack/mem_rdata    read data strobe and data
//   ir_valid             instruction presented to execute
//   op_code/regs/adr     IR1[15:8], IR1[7:0], IR2
//   ir_len2              presented instruction is two words
//   exec_done            execute finished the presented instruction
//   pc_load/pc_load_val  redirect request and target (with exec_done)
//   state/fault          FSM state, bus-timeout fault flag
`timescale 1ns/1ps
module comet2_fetch_unit
    import comet2_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int unsigned        TIMEOUT  = 255
)(
    input  logic              mclk,
    input  logic              rst,
    input  logic              init,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic              ir_valid,
    output logic [7:0]        op_code,
    output logic [7:0]        regs,
    output logic [ADDR_W-1:0] adr,
    output logic              ir_len2,
    input  logic              exec_done,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    output logic [2:0]        state,
    output logic              fault
);

    localparam int unsigned       CNT_W       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [ADDR_W-1:0] PC_ONE      = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       ir1, ir2;
    logic              ir_len2_q;
    logic [CNT_W-1:0]  wait_cnt;

    logic fetch_one, fetch_two, fetch_nop;
    logic timeout_hit;

    // Classify the word arriving from memory so the next state is known in
    // the same cycle as the ack (zero-wait fetch = one cycle per word).
    comet2_oplen_decode u_decode (
        .op_code  (mem_rdata[15:8]),
        .one_word (fetch_one),
        .two_word (fetch_two),
        .is_nop   (fetch_nop)
    );

    // An ack in the timeout cycle takes priority over the fault.
    assign timeout_hit = (TIMEOUT != 0) && !mem_ack && (wait_cnt == TIMEOUT_CNT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge mclk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output of this block is defaulted first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        ir_valid = 1'b0;
        fault    = 1'b0;
        case (state_q)
            ST_IDLE:  if (init) state_d = ST_INIT;
            ST_INIT:  state_d = ST_IFET1;
            ST_IFET1: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    if (fetch_two)      state_d = ST_IFET2;
                    else if (fetch_one) state_d = ST_EXEC;
                    else if (fetch_nop) state_d = ST_IFET1;
                end else if (timeout_hit) begin
                    state_d = ST_FAULT;
                end
            end
            ST_IFET2: begin
                mem_req = 1'b1;
                if (mem_ack)          state_d = ST_EXEC;
                else if (timeout_hit) state_d = ST_FAULT;
            end
            ST_EXEC: begin
                ir_valid = 1'b1;
                if (exec_done) state_d = ST_IFET1;
            end
            ST_FAULT: begin
                fault = 1'b1;
                if (init) state_d = ST_INIT;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // PC, instruction registers and wait counter.
    always_ff @(posedge mclk) begin
        if (rst) begin
            pc        <= RESET_PC;
            ir1       <= '0;
            ir2       <= '0;
            ir_len2_q <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    pc        <= RESET_PC;
                    ir1       <= '0;
                    ir2       <= '0;
                    ir_len2_q <= 1'b0;
                    wait_cnt  <= '0;
                end
                ST_IFET1, ST_IFET2: begin
                    if (mem_ack) begin
                        pc       <= pc + PC_ONE;
                        wait_cnt <= '0;
                        if (state_q == ST_IFET1) begin
                            ir1       <= mem_rdata;
                            ir_len2_q <= fetch_two;
                        end else begin
                            ir2 <= mem_rdata;
                        end
                    end else if (timeout_hit) begin
                        wait_cnt <= '0;
                    end else if (TIMEOUT != 0) begin
                        wait_cnt <= wait_cnt + CNT_ONE;
                    end
                end
                ST_EXEC: begin
                    wait_cnt <= '0;
                    if (exec_done && pc_load) pc <= pc_load_val;
                end
                default: wait_cnt <= '0;
            endcase
        end
    end

    assign mem_addr = pc;
    assign op_code  = ir1[15:8];
    assign regs     = ir1[7:0];
    assign adr      = ADDR_W'(ir2);
    // Length flag captured with IR1, so it always reflects the decode of IR1.
    assign ir_len2  = ir_len2_q;
    assign state    = state_q;

endmodule

// File: tb/tb_comet2_fetch_unit.sv
// tb_comet2_fetch_unit: scoreboard bench for comet2_fetch_unit.
// A reference model walks the memory image from the model PC and queues
// the next expected instruction whenever the bench starts the unit or
// completes an execute handshake; an independent monitor pops and compares
// each time the DUT raises ir_valid. A memory responder inserts wait states.
`timescale 1ns/1ps
module tb_comet2_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  regs;
        logic        len2;
        logic [15:0] adr;
        logic [15:0] pc;
    } exp_t;

    logic        mclk;
    logic        rst, init;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack   = 1'b0;
    logic [15:0] mem_rdata = 16'h0;
    logic        ir_valid;
    logic [7:0]  op_code, regs;
    logic [15:0] adr;
    logic        ir_len2;
    logic        exec_done, pc_load;
    logic [15:0] pc_load_val;
    logic [2:0]  state;
    logic        fault;

    comet2_fetch_unit #(.ADDR_W(16), .RESET_PC(RESET_PC), .TIMEOUT(4)) dut (
        .mclk        (mclk),
        .rst         (rst),
        .init        (init),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .ir_valid    (ir_valid),
        .op_code     (op_code),
        .regs        (regs),
        .adr         (adr),
        .ir_len2     (ir_len2),
        .exec_done   (exec_done),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .state       (state),
        .fault       (fault)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] mem [0:65535];
    exp_t        sb [$];
    logic [15:0] model_pc;
    logic [15:0] next_pc;
    int          fixed_delay = 0;   // <0: random 0..4 wait states per word

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic is_two_word(input logic [7:0] op);
        return op inside {[8'h10:8'h13], [8'h20:8'h23], [8'h30:8'h33], [8'h40:8'h43],
                          [8'h50:8'h53], [8'h60:8'h6F], 8'h70, 8'h80, 8'hF0};
    endfunction

    // Next instruction the fetch stream should deliver starting at pc.
    function automatic void predict(inout logic [15:0] pc, output exp_t e);
        logic [15:0] w;
        int guard = 0;
        w  = mem[pc];
        pc = pc + 16'd1;
        while (w[15:8] == 8'h00 && guard < 1000) begin
            w  = mem[pc];
            pc = pc + 16'd1;
            guard++;
        end
        e.op   = w[15:8];
        e.regs = w[7:0];
        e.len2 = is_two_word(w[15:8]);
        e.adr  = 16'h0;
        if (e.len2) begin
            e.adr = mem[pc];
            pc    = pc + 16'd1;
        end
        e.pc = pc;
    endfunction

    // Memory responder: wait states per word, junk ack when not requested.
    int          waited    = 0;
    int          cur_delay = 0;
    logic [15:0] last_addr = 16'h0;
    always @(negedge mclk) begin
        if (mem_req) begin
            if (waited > 0) check("addr_stable", mem_addr, last_addr);
            else cur_delay = (fixed_delay < 0) ? int'($urandom_range(0, 4)) : fixed_delay;
            last_addr = mem_addr;
            if (waited >= cur_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                waited    = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'($urandom);
                waited++;
            end
        end else begin
            waited    = 0;
            mem_ack   = 1'($urandom);
            mem_rdata = 16'($urandom);
        end
    end

    // Monitor: compare each fresh presentation against the scoreboard.
    logic ir_valid_q = 1'b0;
    always @(negedge mclk) begin
        exp_t e;
        if (ir_valid && !ir_valid_q) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("op_code", op_code, e.op);
                check("regs", regs, e.regs);
                check("ir_len2", ir_len2, e.len2);
                check("exec_pc", mem_addr, e.pc);
                if (e.len2) check("adr", adr, e.adr);
            end
        end
        ir_valid_q = ir_valid;
    end

    task automatic check_reset(input string tag);
        check({tag, "_state"}, state, 3'b000);
        check({tag, "_req"}, mem_req, 1'b0);
        check({tag, "_valid"}, ir_valid, 1'b0);
        check({tag, "_fault"}, fault, 1'b0);
        check({tag, "_len2"}, ir_len2, 1'b0);
        check({tag, "_addr"}, mem_addr, RESET_PC);
        check({tag, "_ir1"}, {op_code, regs}, 16'h0);
        check({tag, "_ir2"}, adr, 16'h0);
    endtask

    task automatic start();
        exp_t e;
        sb.delete();
        model_pc = RESET_PC;
        predict(model_pc, e);
        sb.push_back(e);
        init = 1'b1;
        @(negedge mclk);
        init = 1'b0;
        check("init_state", state, 3'b001);
    endtask

    // Counts negedges until ir_valid; execute-side inputs toggle as noise.
    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge mclk);
            n++;
            if (ir_valid) break;
            exec_done   = 1'($urandom);
            pc_load     = 1'($urandom);
            pc_load_val = 16'($urandom);
        end
        exec_done = 1'b0;
        pc_load   = 1'b0;
        check("ir_valid_seen", ir_valid, 1'b1);
    endtask

    // Completes the presented instruction, optionally redirecting.
    task automatic do_exec(input logic load, input logic [15:0] tgt, input int max_hold);
        exp_t e;
        int   hold;
        hold = $urandom_range(0, max_hold);
        for (int i = 0; i < hold; i++) begin
            pc_load     = 1'($urandom);
            pc_load_val = 16'($urandom);
            @(negedge mclk);
            check("exec_hold", ir_valid, 1'b1);
        end
        exec_done   = 1'b1;
        pc_load     = load;
        pc_load_val = tgt;
        if (load) model_pc = tgt;
        next_pc = model_pc;
        predict(model_pc, e);
        sb.push_back(e);
        @(negedge mclk);
        exec_done = 1'b0;
        pc_load   = 1'b0;
        check("after_exec_state", state, 3'b010);
        check("after_exec_addr", mem_addr, next_pc);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int cnt;
        rst = 1'b1; init = 1'b0; exec_done = 1'b0; pc_load = 1'b0; pc_load_val = 16'h0;
        for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
        mem[16'h0000] = 16'h1012; mem[16'h0001] = 16'hABCD;
        mem[16'h0100] = 16'h2400;
        mem[16'h0101] = 16'h6100; mem[16'h0102] = 16'h0040;
        mem[16'hFFFE] = 16'h7000; mem[16'hFFFF] = 16'h1234;

        repeat (3) @(negedge mclk);
        check_reset("por");
        rst = 1'b0;
        @(negedge mclk);
        check("idle_hold", state, 3'b000);

        // Zero-wait two-word fetch, redirect, one-word, then 3-wait fetch.
        fixed_delay = 0;
        start();
        wait_valid(n);
        check("two_word_latency", n, 3);
        do_exec(1'b1, 16'h0100, 0);
        wait_valid(n);
        check("one_word_latency", n, 1);
        fixed_delay = 3;
        do_exec(1'b0, 16'h0000, 0);
        wait_valid(n);
        check("wait3_latency", n, 8);

        // Reset while in EXEC.
        rst = 1'b1;
        @(negedge mclk);
        check_reset("rst_exec");
        rst = 1'b0;

        // Two NOPs then a one-word op: three IFET1 cycles, then EXEC.
        mem[0] = 16'h0000; mem[1] = 16'h0000; mem[2] = 16'h2400;
        mem[3] = 16'h7000; mem[4] = 16'h1111;
        fixed_delay = 0;
        start();
        wait_valid(n);
        check("nop_latency", n, 4);

        // Reset while in IFET2.
        fixed_delay = 2;
        do_exec(1'b0, 16'h0000, 0);
        for (int i = 0; i < 20 && state != 3'b011; i++) @(negedge mclk);
        check("in_ifet2", state, 3'b011);
        rst = 1'b1;
        @(negedge mclk);
        check_reset("rst_ifet2");
        rst = 1'b0;
        @(negedge mclk);

        // Restart, redirect to the top of memory and wrap through 0xFFFF.
        fixed_delay = -1;
        start();
        wait_valid(n);
        do_exec(1'b1, 16'hFFFE, 2);
        wait_valid(n);
        check("wrap_pc", mem_addr, 16'h0000);
        do_exec(1'b0, 16'h0000, 2);

        // Randomised stream: random wait states, holds and redirects.
        for (int k = 0; k < 150; k++) begin
            wait_valid(n);
            do_exec(($urandom_range(0, 3) == 0), 16'($urandom), 3);
        end

        // Bus timeout: memory never acks; TIMEOUT=4 gives 5 IFET1 cycles.
        wait_valid(n);
        fixed_delay = 1000;
        do_exec(1'b0, 16'h0000, 0);
        cnt = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge mclk);
            if (fault) break;
            cnt++;
        end
        check("fault_flag", fault, 1'b1);
        check("fault_cycles", cnt, 5);
        check("fault_state", state, 3'b101);
        check("fault_req", mem_req, 1'b0);
        check("fault_pc_hold", mem_addr, next_pc);
        @(negedge mclk);
        check("fault_sticky", state, 3'b101);

        sb.delete();
        init = 1'b1;
        @(negedge mclk);
        init = 1'b0;
        check("fault_init_state", state, 3'b001);
        @(negedge mclk);
        check("restart_state", state, 3'b010);
        check("restart_pc", mem_addr, RESET_PC);
        check("restart_fault", fault, 1'b0);
        check("restart_ir", {op_code, regs, adr}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
